// File: rtl/isa_pkg.sv
// Shared ASIP instruction-set definitions: opcodes, field positions and widths.
// The instruction decoder imports the same package so both sides agree on the layout.
package isa_pkg;

  localparam int ARQ     = 16;
  localparam int OP_MSB  = 15;
  localparam int OP_W    = 3;
  localparam int RD_LSB  = 10;
  localparam int RS1_LSB = 7;
  localparam int RS2_LSB = 4;
  localparam int REG_W   = 3;
  localparam int IMM_W   = 10;
  localparam int JADDR_W = 13;

  typedef enum logic [OP_W-1:0] {
    OP_SET   = 3'd0,
    OP_LDPX  = 3'd1,
    OP_MODEX = 3'd2,
    OP_STPX  = 3'd3,
    OP_CMPEQ = 3'd4,
    OP_JEQ   = 3'd5,
    OP_J     = 3'd6,
    OP_ADD   = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Host-side field stream plus instruction-memory write port of the loader.
// Handshake: a field set transfers on a rising clk edge where in_valid and in_ready are both 1.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 13,
  parameter int ARQ    = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [2:0]        in_rd;
  logic [2:0]        in_rs1;
  logic [2:0]        in_rs2;
  logic [9:0]        in_imm;
  logic [ADDR_W-1:0] in_addr;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [ARQ-1:0]    mem_wdata;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   count;

  modport master (
    output start, base_addr, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_addr, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata, done, err, count
  );

  modport slave (
    input  start, base_addr, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_addr, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata, done, err, count
  );
endinterface

// File: rtl/instr_encoder_loader_encode.sv
// Combinational field-to-word encoder; the exact inverse of the decoder's field extraction.
// Fields an opcode does not use never reach the word, so unused bits stay 0.
module instr_encode
  import isa_pkg::*;
(
  input  op_t                i_op,
  input  logic [REG_W-1:0]   i_rd,
  input  logic [REG_W-1:0]   i_rs1,
  input  logic [REG_W-1:0]   i_rs2,
  input  logic [IMM_W-1:0]   i_imm,
  input  logic [JADDR_W-1:0] i_addr,
  output logic [ARQ-1:0]     o_word
);

  always_comb begin
    o_word = '0;
    o_word[OP_MSB -: OP_W] = i_op;
    unique case (i_op)
      OP_SET, OP_ADD: begin
        o_word[RD_LSB +: REG_W] = i_rd;
        o_word[0 +: IMM_W]      = i_imm;
      end
      OP_LDPX, OP_STPX: begin
        o_word[RD_LSB +: REG_W]  = i_rd;
        o_word[RS1_LSB +: REG_W] = i_rs1;
      end
      OP_MODEX: begin
        o_word[RD_LSB +: REG_W]  = i_rd;
        o_word[RS1_LSB +: REG_W] = i_rs1;
        o_word[RS2_LSB +: REG_W] = i_rs2;
      end
      OP_CMPEQ: begin
        o_word[RS1_LSB +: REG_W] = i_rs1;
        o_word[RS2_LSB +: REG_W] = i_rs2;
      end
      OP_JEQ, OP_J: begin
        o_word[0 +: JADDR_W] = i_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes instruction fields and writes them to consecutive
// instruction-memory addresses during boot, stopping on in_last or address overflow.
module instr_encoder_loader #(
  parameter int ARQ    = 16,
  parameter int ADDR_W = 13
) (
  input  logic                clk,
  input  logic                rst,
  instr_encoder_loader_if.slave bus,
  output isa_pkg::ld_state_t  o_state
);
  import isa_pkg::*;

  ld_state_t         r_state;
  ld_state_t         w_next_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [ARQ-1:0]    r_wdata;
  logic              r_done;
  logic              r_err;

  logic              w_hs;
  logic              w_at_end;
  logic              w_ovf;
  logic [ARQ-1:0]    w_word;

  assign w_hs     = r_ready & bus.in_valid;
  assign w_at_end = (r_ptr == {ADDR_W{1'b1}});
  // The top address is still written; only a non-final word landing there is an overflow.
  assign w_ovf    = w_hs & ~bus.in_last & w_at_end;

  instr_encode u_encode (
    .i_op   (op_t'(bus.in_op)),
    .i_rd   (bus.in_rd),
    .i_rs1  (bus.in_rs1),
    .i_rs2  (bus.in_rs2),
    .i_imm  (bus.in_imm),
    .i_addr (bus.in_addr),
    .o_word (w_word)
  );

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (bus.start) w_next_state = ST_LOAD;
      ST_LOAD: if (w_hs && (bus.in_last || w_at_end)) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // in_ready and done are derived from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= (w_next_state == ST_LOAD);
      r_done  <= (w_next_state == ST_DONE);
      r_we    <= w_hs;
      if (r_state == ST_IDLE && bus.start) begin
        r_ptr   <= bus.base_addr;
        r_count <= '0;
        r_err   <= 1'b0;
      end
      if (w_hs) begin
        r_addr  <= r_ptr;
        r_wdata <= w_word;
        r_count <= r_count + (ADDR_W+1)'(1);
        if (!w_at_end) r_ptr <= r_ptr + ADDR_W'(1);
        if (w_ovf)     r_err <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = r_ready;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.count     = r_count;
  assign o_state       = r_state;

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Converts structured instruction fields (opcode, register indices, immediate, jump address) into 16-bit ASIP instruction words and streams them into instruction memory at consecutive addresses. It is the producing side of the instruction decoder: every word it writes must decode back to the same fields. It sits between the host/boot program source and the instruction memory write port, and it is used during program load before the core is released from reset.

## Interface

Parameters:
- ARQ, 16, instruction word width; the encoding below is defined only for 16.
- ADDR_W, 13, instruction memory address width; this equals the jump address field width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a load session; sampled only in IDLE.
- base_addr  in  ADDR_W  first write address; captured on start.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  loader can accept fields.
- in_op  in  3  opcode: SET=0, LDPX=1, MODEX=2, STPX=3, CMPEQ=4, JEQ=5, J=6, ADD=7.
- in_rd  in  3  destination / source-destination register.
- in_rs1  in  3  source register 1.
- in_rs2  in  3  source register 2.
- in_imm  in  10  immediate.
- in_addr  in  ADDR_W  jump target.
- in_last  in  1  marks the final instruction of the session.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  ARQ  encoded instruction.
- done  out  1  one-cycle pulse when the session ends.
- err  out  1  address overflow flag; sticky until the next accepted start.
- count  out  ADDR_W+1  number of words written in the current session.

## Operation

- Encoding: [15:13] = op in all formats; unused bits = 0.
  - SET, ADD: [12:10] rd, [9:0] imm.
  - LDPX, STPX: [12:10] rd, [9:7] rs1.
  - MODEX: [12:10] rd, [9:7] rs1, [6:4] rs2.
  - CMPEQ: [12:10] = 0, [9:7] rs1, [6:4] rs2.
  - JEQ, J: [12:0] addr.
- Fields that are not used by an opcode are ignored, regardless of their value.
- State machine:
  - IDLE, with in_ready = 0: when start = 1, capture base_addr into the write pointer, clear count and err, then go to LOAD.
  - LOAD, with in_ready = 1: on each handshake (in_valid & in_ready), register the encoded word and the pointer for writing, then increment the pointer.
  - When the accepted word has in_last = 1, go to DONE.
  - When the accepted word has in_last = 0 and the pointer equals 2^ADDR_W - 1, write the word, set err, and go to DONE. The pointer is never wrapped.
  - DONE, with in_ready = 0: done = 1 for exactly one cycle, then go to IDLE.
- start in LOAD or DONE is ignored.
- A reset in the middle of a session abandons it. No further mem_we is issued after reset.

## Timing

- All outputs are registered.
- Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, done 0, err 0, count 0; state IDLE.
- start sampled at edge N: in_ready = 1 from cycle N+1.
- Handshake at edge N: mem_we = 1 with the corresponding mem_addr and mem_wdata during cycle N+1, and count increments at the same time. Back-to-back handshakes give one write per cycle.
- Last or overflow handshake at edge N: during cycle N+1, mem_we = 1, done = 1, and in_ready = 0 (err = 1 in the overflow case). The block is in IDLE in cycle N+2.
- mem_we is low in every cycle that does not follow a handshake.

## Structure

- Package isa_pkg holds the following, shared with the decoder:
  - opcode enum op_t.
  - field bit positions (OP_MSB = 15, RD_LSB = 10, RS1_LSB = 7, RS2_LSB = 4).
  - field widths (REG_W = 3, IMM_W = 10).
  - the ARQ constant.
- One sub-module, instr_encode: purely combinational, maps the fields to a 16-bit word.
- The top level holds the FSM, pointer, count, and output registers.

## Test plan

- Start with base_addr = 0, then stream SET rd=2 imm=16 and the session's last instruction ADD rd=3 imm=15 (in_last = 1) -> mem_addr 0 gets 16'b0000100000010000 and mem_addr 1 gets 16'b1110110000001111; done pulses together with the second write; count = 2.
- Start with base_addr = 0x100 and stream all formats back-to-back:
  - LDPX rd=1 rs1=2 -> 16'b0010010100000000 at 0x100.
  - MODEX rd=0 rs1=1 rs2=2 -> 16'b0100000010100000 at 0x101.
  - CMPEQ rs1=5 rs2=6 -> 16'b1000001011100000 at 0x102.
  - JEQ addr=4 -> 16'b1010000000000100 at 0x103.
  - J addr=5 with in_last = 1 -> 16'b1100000000000101 at 0x104.
  - Required: one write per cycle; count = 5.
- Hold in_valid = 0 for 3 cycles in the middle of a session -> no mem_we during those cycles, and the pointer is unchanged.
- Start with base_addr = 0x1FFE and stream 3 words with in_last = 0 -> writes at 0x1FFE and 0x1FFF; err = 1 and done = 1 with the second write; the third word is never accepted (in_ready = 0).
- Assert rst during LOAD after 2 writes -> all outputs return to their reset values on the next cycle, and a following start restarts cleanly from the new base_addr.
- Pulse start during LOAD and during DONE -> no effect; base_addr is not recaptured.
